// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache with one-word lines.
// It answers CPU strobe/mfc requests and fetches misses from slowmem using the same protocol.
module dm_cache_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_strobe,
  input  logic              cpu_rnotw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_mfc,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic              mem_strobe,
  output logic              mem_rnotw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_mfc,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {IDLE, WB, FILL, WAIT} state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic                cpu_mfc_q, cpu_mfc_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_busy_q, cpu_busy_d;
  logic                mem_strobe_q, mem_strobe_d;
  logic                mem_rnotw_q, mem_rnotw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [15:0]         hit_q, hit_d;
  logic [15:0]         miss_q, miss_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic                req_rnotw_q, req_rnotw_d;

  // Tag and data storage carry no reset; the valid bits qualify them.
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [DATA_W-1:0]   data_mem [LINES];

  logic                arr_we;
  logic [INDEX_W-1:0]  arr_idx;
  logic [TAG_W-1:0]    arr_tag;
  logic [DATA_W-1:0]   arr_data;

  logic [INDEX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]    cpu_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [TAG_W-1:0]    line_tag;
  logic [DATA_W-1:0]   line_data;
  logic                line_hit;
  logic                victim_dirty;

  assign cpu_idx      = cpu_addr[INDEX_W-1:0];
  assign cpu_tag      = cpu_addr[ADDR_W-1:INDEX_W];
  assign req_idx      = req_addr_q[INDEX_W-1:0];
  assign req_tag      = req_addr_q[ADDR_W-1:INDEX_W];
  assign line_tag     = tag_mem[cpu_idx];
  assign line_data    = data_mem[cpu_idx];
  assign line_hit     = valid_q[cpu_idx] && (line_tag == cpu_tag);
  assign victim_dirty = valid_q[cpu_idx] && dirty_q[cpu_idx];

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    cpu_mfc_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_busy_d   = cpu_busy_q;
    mem_strobe_d = 1'b0;
    mem_rnotw_d  = mem_rnotw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_rnotw_d  = req_rnotw_q;
    arr_we       = 1'b0;
    arr_idx      = cpu_idx;
    arr_tag      = cpu_tag;
    arr_data     = cpu_wdata;

    unique case (state_q)
      IDLE: begin
        if (cpu_strobe) begin
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          req_rnotw_d = cpu_rnotw;
          if (line_hit) begin
            hit_d = hit_q + 16'd1;
            if (cpu_rnotw) begin
              cpu_mfc_d   = 1'b1;
              cpu_rdata_d = line_data;
            end else begin
              arr_we           = 1'b1;
              dirty_d[cpu_idx] = 1'b1;
            end
          end else begin
            miss_d = miss_q + 16'd1;
            if (victim_dirty) begin
              state_d      = WB;
              cpu_busy_d   = 1'b1;
              mem_strobe_d = 1'b1;
              mem_rnotw_d  = 1'b0;
              mem_addr_d   = {line_tag, cpu_idx};
              mem_wdata_d  = line_data;
            end else if (!cpu_rnotw) begin
              // Clean victim on a write miss: allocate in place, no memory traffic.
              arr_we           = 1'b1;
              valid_d[cpu_idx] = 1'b1;
              dirty_d[cpu_idx] = 1'b1;
            end else begin
              state_d      = FILL;
              cpu_busy_d   = 1'b1;
              mem_strobe_d = 1'b1;
              mem_rnotw_d  = 1'b1;
              mem_addr_d   = cpu_addr;
            end
          end
        end
      end
      WB: begin
        if (req_rnotw_q) begin
          state_d      = FILL;
          mem_strobe_d = 1'b1;
          mem_rnotw_d  = 1'b1;
          mem_addr_d   = req_addr_q;
        end else begin
          arr_we           = 1'b1;
          arr_idx          = req_idx;
          arr_tag          = req_tag;
          arr_data         = req_wdata_q;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b1;
          cpu_busy_d       = 1'b0;
          state_d          = IDLE;
        end
      end
      FILL: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_mfc) begin
          arr_we           = 1'b1;
          arr_idx          = req_idx;
          arr_tag          = req_tag;
          arr_data         = mem_rdata;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          cpu_mfc_d        = 1'b1;
          cpu_rdata_d      = mem_rdata;
          cpu_busy_d       = 1'b0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      cpu_mfc_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_busy_q   <= 1'b0;
      mem_strobe_q <= 1'b0;
      mem_rnotw_q  <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_rnotw_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      cpu_mfc_q    <= cpu_mfc_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_busy_q   <= cpu_busy_d;
      mem_strobe_q <= mem_strobe_d;
      mem_rnotw_q  <= mem_rnotw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_rnotw_q  <= req_rnotw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_mem[arr_idx]  <= arr_tag;
      data_mem[arr_idx] <= arr_data;
    end
  end

  assign cpu_mfc    = cpu_mfc_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_busy   = cpu_busy_q;
  assign mem_strobe = mem_strobe_q;
  assign mem_rnotw  = mem_rnotw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: slowmem model (MEMDELAY 4) plus a line-level cache model
// and a flat "true memory" image that every read must agree with.
module tb_dm_cache_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_strobe = 1'b0;
  logic        cpu_rnotw = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_mfc;
  logic [15:0] cpu_rdata;
  logic        cpu_busy;
  logic        mem_strobe;
  logic        mem_rnotw;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_mfc = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  dm_cache_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_strobe(cpu_strobe), .cpu_rnotw(cpu_rnotw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_mfc(cpu_mfc), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .mem_strobe(mem_strobe), .mem_rnotw(mem_rnotw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mfc(mem_mfc), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Slowmem: writes land at the sampling edge, reads answer 4 edges later.
  logic [15:0] smem [512];
  bit          mem_ready = 1'b0;
  int          rd_cnt = 0;
  logic [15:0] rd_addr = '0;
  int          strobe_cnt = 0;

  always @(posedge clk) begin
    mem_mfc <= 1'b0;
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) smem[i] <= 16'(i) ^ 16'h5A00;
      smem[16] <= 16'hA5A5;
      mem_ready <= 1'b1;
    end else begin
      if (rd_cnt == 1) begin
        mem_mfc   <= 1'b1;
        mem_rdata <= smem[rd_addr[8:0]];
      end
      if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
      if (mem_strobe) begin
        strobe_cnt <= strobe_cnt + 1;
        if (mem_rnotw) begin
          rd_cnt  <= 4;
          rd_addr <= mem_addr;
        end else begin
          smem[mem_addr[8:0]] <= mem_wdata;
        end
      end
    end
  end

  // Reference model: what memory should contain, and which word each line holds.
  logic [15:0] truth [512];
  bit          mv [8];
  bit          md [8];
  logic [12:0] mt [8];
  logic [15:0] mdat [8];
  int          exp_hits = 0;
  int          exp_misses = 0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // One CPU transaction, entered and left at a negedge with the cache idle.
  // inject=1 pokes a write while a read miss is waiting; it must be dropped.
  task automatic do_op(input bit rd, input logic [15:0] a, input logic [15:0] wd, input bit inject);
    int          idx;
    logic [12:0] tg;
    bit          hit;
    bit          vd;
    logic [15:0] vaddr;
    logic [15:0] vdata;
    int          s0;
    int          k;
    int          exp_strobes;
    idx   = int'(a[2:0]);
    tg    = a[15:3];
    hit   = mv[idx] && (mt[idx] == tg);
    vd    = mv[idx] && md[idx];
    vaddr = {mt[idx], a[2:0]};
    vdata = mdat[idx];
    s0    = strobe_cnt;
    cpu_strobe = 1'b1;
    cpu_rnotw  = rd;
    cpu_addr   = a;
    cpu_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    cpu_strobe = 1'b0;
    k = 0;
    if (hit) begin
      exp_hits++;
      check("hit_busy", 32'(cpu_busy), 0);
      check("hit_memstrobe", 32'(mem_strobe), 0);
      if (rd) begin
        check("rdhit_mfc", 32'(cpu_mfc), 1);
        check("rdhit_data", 32'(cpu_rdata), 32'(truth[a[8:0]]));
      end else begin
        check("wrhit_mfc", 32'(cpu_mfc), 0);
        truth[a[8:0]] = wd;
        mdat[idx] = wd;
        md[idx] = 1'b1;
      end
    end else begin
      exp_misses++;
      if (vd) begin
        check("wb_busy", 32'(cpu_busy), 1);
        check("wb_strobe", 32'(mem_strobe), 1);
        check("wb_rnotw", 32'(mem_rnotw), 0);
        check("wb_addr", 32'(mem_addr), 32'(vaddr));
        check("wb_data", 32'(mem_wdata), 32'(vdata));
      end
      if (!rd) begin
        if (!vd) begin
          check("wrmiss_busy", 32'(cpu_busy), 0);
          check("wrmiss_strobe", 32'(mem_strobe), 0);
        end else begin
          @(posedge clk);
          @(negedge clk);
          check("wrmiss_busy_end", 32'(cpu_busy), 0);
        end
        truth[a[8:0]] = wd;
        mv[idx] = 1'b1; md[idx] = 1'b1; mt[idx] = tg; mdat[idx] = wd;
      end else begin
        if (!vd) begin
          check("fill_strobe", 32'(mem_strobe), 1);
          check("fill_rnotw", 32'(mem_rnotw), 1);
          check("fill_addr", 32'(mem_addr), 32'(a));
        end
        while (!cpu_mfc && k < 20) begin
          cpu_strobe = inject && (k == 3);
          cpu_rnotw  = 1'b0;
          cpu_wdata  = 16'hDEAD;
          @(posedge clk);
          @(negedge clk);
          cpu_strobe = 1'b0;
          k++;
        end
        check("rdmiss_latency", 32'(k), vd ? 7 : 6);
        check("rdmiss_data", 32'(cpu_rdata), 32'(truth[a[8:0]]));
        check("rdmiss_busy_end", 32'(cpu_busy), 0);
        mv[idx] = 1'b1; md[idx] = 1'b0; mt[idx] = tg; mdat[idx] = truth[a[8:0]];
      end
    end
    exp_strobes = hit ? 0 : ((vd ? 1 : 0) + (rd ? 1 : 0));
    check("mem_strobes", 32'(strobe_cnt - s0), 32'(exp_strobes));
    check("hit_count", 32'(hit_count), 32'(exp_hits[15:0]));
    check("miss_count", 32'(miss_count), 32'(exp_misses[15:0]));
    $display("op %s addr=%04h wdata=%04h %s%s lat=%0d rdata=%04h hits=%0d misses=%0d",
             rd ? "RD" : "WR", a, wd, hit ? "hit" : "miss", vd && !hit ? "+wb" : "",
             k, cpu_rdata, hit_count, miss_count);
  endtask

  initial begin
    logic [15:0] ra;
    bit          resident_dirty;
    for (int i = 0; i < 512; i++) truth[i] = 16'(i) ^ 16'h5A00;
    truth[16] = 16'hA5A5;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_mfc", 32'(cpu_mfc), 0);
    check("rst_busy", 32'(cpu_busy), 0);
    check("rst_strobe", 32'(mem_strobe), 0);
    check("rst_rnotw", 32'(mem_rnotw), 1);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_rdata", 32'(cpu_rdata), 0);
    check("rst_hits", 32'(hit_count), 0);
    check("rst_misses", 32'(miss_count), 0);
    reset = 1'b0;
    @(negedge clk);

    do_op(1'b1, 16'h0010, 16'h0000, 1'b0);
    do_op(1'b1, 16'h0010, 16'h0000, 1'b0);
    do_op(1'b0, 16'h0010, 16'h1234, 1'b0);
    do_op(1'b1, 16'h0010, 16'h0000, 1'b0);
    check("smem_before_wb", 32'(smem[16]), 32'h0000A5A5);
    do_op(1'b1, 16'h0018, 16'h0000, 1'b0);
    check("smem_after_wb", 32'(smem[16]), 32'h00001234);
    do_op(1'b0, 16'h0021, 16'hBEEF, 1'b0);
    do_op(1'b1, 16'h0021, 16'h0000, 1'b0);
    do_op(1'b1, 16'h002A, 16'h0000, 1'b1);
    do_op(1'b1, 16'h002A, 16'h0000, 1'b0);

    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom_range(0, 63));
      do_op(1'($urandom_range(0, 1)), ra, 16'($urandom), 1'b0);
    end

    // Anything not held dirty in the cache must already be back in slowmem.
    for (int a = 0; a < 64; a++) begin
      resident_dirty = mv[a % 8] && md[a % 8] && (mt[a % 8] == 13'(a / 8));
      if (!resident_dirty) check("flush_smem", 32'(smem[a]), 32'(truth[a]));
    end

    // Reset while a fill is waiting on slowmem.
    cpu_strobe = 1'b1;
    cpu_rnotw  = 1'b1;
    cpu_addr   = 16'h0105;
    @(posedge clk);
    @(negedge clk);
    cpu_strobe = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_mfc", 32'(cpu_mfc), 0);
    check("midrst_busy", 32'(cpu_busy), 0);
    check("midrst_strobe", 32'(mem_strobe), 0);
    check("midrst_rnotw", 32'(mem_rnotw), 1);
    check("midrst_hits", 32'(hit_count), 0);
    check("midrst_misses", 32'(miss_count), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (10) begin
      @(negedge clk);
      check("stray_mfc_ignored", 32'(cpu_mfc), 0);
    end
    do_op(1'b1, 16'h0105, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
